hp_result_buffer: RTL

//   Output stage directly downstream of the half-precision adder (hp_adder).

---
 rtl/fp_alu_pkg.sv | 16 +
 rtl/hp_result_fifo.sv | 55 +++++
 rtl/hp_result_buffer.sv | 83 ++++++++
 3 files changed

// File: rtl/fp_alu_pkg.sv
// Shared definitions for the half-precision ALU datapath.
// Holds the result width, the adder exception-flag encoding and the sticky bit positions.
package fp_alu_pkg;

  localparam int HP_W = 16;

  localparam logic [1:0] FLG_NONE = 2'b00;
  localparam logic [1:0] FLG_OF   = 2'b01;
  localparam logic [1:0] FLG_UF   = 2'b10;
  localparam logic [1:0] FLG_INV  = 2'b11;

  localparam int STK_INV = 2;
  localparam int STK_OF  = 1;
  localparam int STK_UF  = 0;

endpackage

// File: rtl/hp_result_fifo.sv
// Show-ahead register FIFO with an occupancy counter.
// Storage has no reset; the read port is forced to zero whenever the FIFO is empty.
module hp_result_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/hp_result_buffer.sv
// Registered, back-pressurable result stage behind the half-precision adder.
// Buffers {sum, flag} results and accumulates sticky exception status and an event count.
module hp_result_buffer
  import fp_alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [HP_W-1:0]        in_sum,
  input  logic [1:0]             in_flag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [HP_W-1:0]        out_sum,
  output logic [1:0]             out_flag,
  output logic [$clog2(DEPTH):0] level,
  output logic [2:0]             sticky,
  output logic [CNT_W-1:0]       exc_cnt,
  input  logic                   clr_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [HP_W+1:0]  rd_data;
  logic [2:0]       sticky_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // in_ready comes only from the registered level, never from out_ready.
  assign in_ready  = ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_sum   = rd_data[HP_W+1:2];
  assign out_flag  = rd_data[1:0];

  hp_result_fifo #(
    .W     (HP_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data ({in_sum, in_flag}),
    .rd_data (rd_data),
    .level   (level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Clear is applied first so a flagged push in the same cycle survives it.
  always_comb begin
    sticky_nxt = clr_sticky ? 3'b000 : sticky;
    cnt_nxt    = clr_sticky ? '0 : exc_cnt;
    if (push) begin
      case (in_flag)
        FLG_OF:  sticky_nxt[STK_OF]  = 1'b1;
        FLG_UF:  sticky_nxt[STK_UF]  = 1'b1;
        FLG_INV: sticky_nxt[STK_INV] = 1'b1;
        default: ;
      endcase
      if (in_flag != FLG_NONE && cnt_nxt != CNT_MAX) cnt_nxt = cnt_nxt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky  <= 3'b000;
      exc_cnt <= '0;
    end else begin
      sticky  <= sticky_nxt;
      exc_cnt <= cnt_nxt;
    end
  end

endmodule
